program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; every flop updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  begin load-and-run sequence; sampled only in IDLE.
REQ-004 SHALL have port: abort  input  1  cancel any sequence; returns to IDLE.
REQ-005 SHALL have port: load_count  input  4  instruction words to load, legal 1..8.
REQ-006 SHALL have port: run_cycles  input  8  clock cycles to hold PC_Enable high; 0 = run until abort.
REQ-007 SHALL have port: ld_valid  input  1  loader source word valid.
REQ-008 SHALL have port: ld_data  input  11  loader source instruction word.
REQ-009 SHALL have port: ld_ready  output  1  loader accepts word this cycle.
REQ-010 SHALL have port: RAM_Write_Enable  output  1  CPU instruction RAM write strobe.
REQ-011 SHALL have port: RAM_Write_Address  output  3  CPU instruction RAM write address.
REQ-012 SHALL have port: RAM_Write_Data  output  11  CPU instruction RAM write data.
REQ-013 SHALL have port: cpu_reset  output  1  drives CPU reset.
REQ-014 SHALL have port: PC_Enable  output  1  CPU program-counter enable.
REQ-015 SHALL have port: busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port: done  output  1  one-cycle pulse on normal run completion.
REQ-017 SHALL have port: error  output  1  one-cycle pulse on illegal load_count.

Function
REQ-018 SHALL implement states IDLE, LOAD, START, RUN, FINISH; all outputs registered.
REQ-019 IDLE: start=1 with load_count in 1..8 SHALL latch load_count and run_cycles, clear write pointer to 0, go LOAD.
REQ-020 IDLE: start=1 with load_count=0 or >8 SHALL stay IDLE and pulse error next cycle; no RAM write.
REQ-021 LOAD: ld_ready SHALL be 1 and cpu_reset SHALL be 1; PC_Enable SHALL be 0.
REQ-022 LOAD: each ld_valid&ld_ready cycle SHALL produce, next cycle, RAM_Write_Enable=1, RAM_Write_Address=pointer, RAM_Write_Data=ld_data, then increment pointer.
REQ-023 RAM_Write_Enable SHALL be 0 in any cycle following no handshake; ld_valid low SHALL stall without timeout.
REQ-024 Accepting the word with pointer = latched load_count-1 SHALL drop ld_ready next cycle and go START; pointer 7 SHALL not wrap into further writes.
REQ-025 START SHALL last exactly one cycle, cpu_reset=1, RAM_Write_Enable=1 only for the final word's write, then go RUN.
REQ-026 RUN: cpu_reset=0, PC_Enable=1; run counter starts at 0 and increments each cycle.
REQ-027 RUN with run_cycles=N>0 SHALL hold PC_Enable high exactly N cycles, then go FINISH with PC_Enable=0.
REQ-028 RUN with run_cycles=0 SHALL hold PC_Enable indefinitely until abort; run counter saturates at 255.
REQ-029 FINISH SHALL last one cycle with done=1, then go IDLE.
REQ-030 abort=1 in any non-IDLE state SHALL, next cycle, force IDLE, RAM_Write_Enable=0, PC_Enable=0, cpu_reset=1, ld_ready=0; no done pulse.
REQ-031 abort has priority over start and ld_valid in the same cycle; start outside IDLE SHALL be ignored.
REQ-032 IDLE SHALL hold cpu_reset=1, PC_Enable=0, ld_ready=0, RAM_Write_Enable=0.

Reset
REQ-033 reset=1 SHALL, at next rising edge, force IDLE, pointer=0, run counter=0, ld_ready=0, RAM_Write_Enable=0, RAM_Write_Address=0, RAM_Write_Data=0, cpu_reset=1, PC_Enable=0, busy=0, done=0, error=0.
REQ-034 reset SHALL override abort, start and any in-flight handshake, including mid-LOAD and mid-RUN.

Verification
REQ-035 start, load_count=6, six back-to-back words 0x603,0x680,0x408,0x190,0x302,0x5F0 -> writes to addresses 0..5 in order, one per cycle, then one START cycle, PC_Enable high.
REQ-036 load_count=2, run_cycles=8, ld_valid gapped 3 cycles between words -> exactly 2 writes, PC_Enable high exactly 8 cycles, done pulses once, busy low after.
REQ-037 load_count=0 and separately 9 with start -> error pulse one cycle, busy stays 0, no RAM_Write_Enable.
REQ-038 load_count=8 -> writes to addresses 0..7, no ninth write even with ld_valid held high.
REQ-039 abort after 3rd word and separately at RUN cycle 4 -> next cycle PC_Enable=0, RAM_Write_Enable=0, cpu_reset=1, no done.
REQ-040 reset asserted mid-RUN with run_cycles=0 -> all outputs at REQ-033 values next edge; subsequent start works normally.

Source files
------------

// File: rtl/program_loader_if.sv
// Control, loader-source and CPU-side signals of the program loader, bundled for port hookup.
// master = the driving environment, slave = program_loader.
interface program_loader_if;
    logic        start;
    logic        abort;
    logic [3:0]  load_count;
    logic [7:0]  run_cycles;
    logic        ld_valid;
    logic [10:0] ld_data;
    logic        ld_ready;
    logic        RAM_Write_Enable;
    logic [2:0]  RAM_Write_Address;
    logic [10:0] RAM_Write_Data;
    logic        cpu_reset;
    logic        PC_Enable;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, abort, load_count, run_cycles, ld_valid, ld_data,
        input  ld_ready, RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data,
               cpu_reset, PC_Enable, busy, done, error
    );

    modport slave (
        input  start, abort, load_count, run_cycles, ld_valid, ld_data,
        output ld_ready, RAM_Write_Enable, RAM_Write_Address, RAM_Write_Data,
               cpu_reset, PC_Enable, busy, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Loads up to 8 instruction words into CPU RAM, releases CPU reset and runs it for a set cycle count.
// Latency: each accepted word is written one cycle after its handshake; all outputs registered.
// Backpressure: ld_ready is high for the whole LOAD phase; a low ld_valid simply stalls, no timeout.
module program_loader (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FINISH} state_t;

    state_t      state;
    logic [2:0]  ptr;
    logic [3:0]  len;
    logic [7:0]  run_len;
    logic [7:0]  run_cnt;

    logic legal_count;
    logic last_word;
    logic run_last;

    assign legal_count = (bus.load_count != 4'd0) && (bus.load_count <= 4'd8);
    assign last_word   = ({1'b0, ptr} == (len - 4'd1));
    // run_len == 0 means free-run; only abort or reset ends it.
    assign run_last    = (run_len != 8'd0) && (run_cnt == (run_len - 8'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            ptr                   <= 3'd0;
            len                   <= 4'd0;
            run_len               <= 8'd0;
            run_cnt               <= 8'd0;
            bus.ld_ready          <= 1'b0;
            bus.RAM_Write_Enable  <= 1'b0;
            bus.RAM_Write_Address <= 3'd0;
            bus.RAM_Write_Data    <= 11'd0;
            bus.cpu_reset         <= 1'b1;
            bus.PC_Enable         <= 1'b0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.error             <= 1'b0;
        end else begin
            bus.RAM_Write_Enable <= 1'b0;
            bus.done             <= 1'b0;
            bus.error            <= 1'b0;

            if (bus.abort && (state != IDLE)) begin
                state         <= IDLE;
                bus.ld_ready  <= 1'b0;
                bus.cpu_reset <= 1'b1;
                bus.PC_Enable <= 1'b0;
                bus.busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            if (legal_count) begin
                                state        <= LOAD;
                                len          <= bus.load_count;
                                run_len      <= bus.run_cycles;
                                ptr          <= 3'd0;
                                bus.ld_ready <= 1'b1;
                                bus.busy     <= 1'b1;
                            end else begin
                                bus.error <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (bus.ld_valid && bus.ld_ready) begin
                            bus.RAM_Write_Enable  <= 1'b1;
                            bus.RAM_Write_Address <= ptr;
                            bus.RAM_Write_Data    <= bus.ld_data;
                            ptr                   <= ptr + 3'd1;
                            if (last_word) begin
                                state        <= START;
                                bus.ld_ready <= 1'b0;
                            end
                        end
                    end
                    START: begin
                        state         <= RUN;
                        bus.cpu_reset <= 1'b0;
                        bus.PC_Enable <= 1'b1;
                        run_cnt       <= 8'd0;
                    end
                    RUN: begin
                        if (run_last) begin
                            state         <= FINISH;
                            bus.PC_Enable <= 1'b0;
                            bus.cpu_reset <= 1'b1;
                            bus.done      <= 1'b1;
                        end else if (run_cnt != 8'hFF) begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                    FINISH: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: stimulus pushes expected RAM writes, a negedge monitor checks them.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset;

    program_loader_if bus();

    program_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [10:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [10:0] words[8];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt, first_wr, last_wr;
    int pc_cnt, pc_runs, pc_first, pc_last;
    int done_cnt, done_cyc, err_cnt, busy_seen;
    logic pc_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on every RAM write, plus per-cycle event bookkeeping.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (bus.RAM_Write_Enable === 1'b1) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write",
                         bus.RAM_Write_Address, bus.RAM_Write_Data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {29'd0, bus.RAM_Write_Address}, {29'd0, e.addr});
                chk("wr_data", {21'd0, bus.RAM_Write_Data}, {21'd0, e.data});
            end
        end
        if (bus.PC_Enable === 1'b1) begin
            if (pc_prev !== 1'b1) pc_runs++;
            if (pc_cnt == 0) pc_first = cyc;
            pc_cnt++;
            pc_last = cyc;
            chk("pc_implies_cpu_run", {31'd0, bus.cpu_reset}, 32'd0);
        end
        pc_prev = bus.PC_Enable;
        if (bus.ld_ready === 1'b1) chk("ld_ready_implies_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.error === 1'b1) err_cnt++;
        if (bus.busy === 1'b1) busy_seen++;
    end

    task automatic clear_stats();
        exp_q.delete();
        wr_cnt = 0; first_wr = 0; last_wr = 0;
        pc_cnt = 0; pc_runs = 0; pc_first = 0; pc_last = 0;
        done_cnt = 0; done_cyc = 0; err_cnt = 0; busy_seen = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) words[i] = 11'($urandom_range(0, 2047));
    endtask

    task automatic begin_seq(input int lc, input int rc);
        clear_stats();
        bus.load_count = 4'(lc);
        bus.run_cycles = 8'(rc);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    // Offer n words; each is held until taken, then ld_valid drops for gap cycles.
    task automatic load_words(input int n, input int gap, input int extra);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int b;
            bus.ld_valid = 1'b1;
            bus.ld_data  = words[i];
            acc = 1'b0;
            b   = 0;
            while (!acc && b < 40) begin
                @(negedge clk);
                acc = (bus.ld_ready === 1'b1);
                @(posedge clk); #1;
                b++;
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL ld_ready_timeout: word %0d not accepted in 40 cycles, expected acceptance", i);
                bus.ld_valid = 1'b0;
                return;
            end
            exp_q.push_back({i[2:0], words[i]});
            if (i < n - 1 && gap > 0) begin
                bus.ld_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        if (extra > 0) begin
            bus.ld_data = 11'h7FF;
            repeat (extra) begin @(posedge clk); #1; end
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (bus.busy === 1'b1 && b < bound);
        chk("idle_reached", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_seq(input int lc, input int rc, input int gap, input int extra);
        begin_seq(lc, rc);
        load_words(lc, gap, extra);
        wait_idle(rc + 40);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("write_count", wr_cnt, lc);
        chk("write_spacing", last_wr - first_wr, (lc - 1) * (gap + 1));
        chk("pc_after_start", pc_first, last_wr + 1);
        chk("pc_cycles", pc_cnt, rc);
        chk("pc_runs", pc_runs, 1);
        chk("done_count", done_cnt, 1);
        chk("done_after_pc", done_cyc, pc_last + 1);
        chk("no_error", err_cnt, 0);
        chk("idle_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("idle_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    endtask

    task automatic illegal_seq(input int lc);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 11'h155;
        begin_seq(lc, 5);
        repeat (4) begin @(posedge clk); #1; end
        bus.ld_valid = 1'b0;
        chk("error_pulse", err_cnt, 1);
        chk("error_busy", busy_seen, 0);
        chk("error_no_write", wr_cnt, 0);
    endtask

    task automatic wait_pc_high();
        int b = 0;
        while (bus.PC_Enable !== 1'b1 && b < 20) begin
            @(negedge clk);
            b++;
        end
        chk("pc_rises", {31'd0, bus.PC_Enable}, 32'd1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.load_count = 4'd0;
        bus.run_cycles = 8'd0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = 11'd0;
        clear_stats();
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("rst_we", {31'd0, bus.RAM_Write_Enable}, 32'd0);
        chk("rst_addr", {29'd0, bus.RAM_Write_Address}, 32'd0);
        chk("rst_data", {21'd0, bus.RAM_Write_Data}, 32'd0);
        chk("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("rst_pc", {31'd0, bus.PC_Enable}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Six back-to-back words
        words[0] = 11'h603; words[1] = 11'h680; words[2] = 11'h408;
        words[3] = 11'h190; words[4] = 11'h302; words[5] = 11'h5F0;
        run_seq(6, 5, 0, 0);

        // Two gapped words, eight run cycles
        fill_random();
        run_seq(2, 8, 3, 0);

        illegal_seq(0);
        illegal_seq(9);

        // Full eight words with ld_valid held afterwards
        fill_random();
        run_seq(8, 4, 0, 4);

        // Abort in LOAD right after the third word, with a fourth offered
        fill_random();
        begin_seq(6, 10);
        load_words(3, 0, 0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 11'h2AA;
        bus.abort    = 1'b1;
        @(posedge clk); #1;
        bus.abort    = 1'b0;
        bus.ld_valid = 1'b0;
        chk("abl_pc", {31'd0, bus.PC_Enable}, 32'd0);
        chk("abl_we", {31'd0, bus.RAM_Write_Enable}, 32'd0);
        chk("abl_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("abl_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("abl_busy", {31'd0, bus.busy}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        chk("abl_writes", wr_cnt, 3);
        chk("abl_no_done", done_cnt, 0);

        // Abort at RUN cycle 4
        fill_random();
        begin_seq(2, 20);
        load_words(2, 0, 0);
        wait_pc_high();
        repeat (3) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abr_pc", {31'd0, bus.PC_Enable}, 32'd0);
        chk("abr_we", {31'd0, bus.RAM_Write_Enable}, 32'd0);
        chk("abr_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("abr_busy", {31'd0, bus.busy}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        chk("abr_pc_cycles", pc_cnt, 4);
        chk("abr_no_done", done_cnt, 0);

        // Free run past counter saturation, then reset mid-RUN
        fill_random();
        begin_seq(3, 0);
        load_words(3, 0, 0);
        wait_pc_high();
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("freerun_pc_held", {31'd0, bus.PC_Enable}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("mrst_we", {31'd0, bus.RAM_Write_Enable}, 32'd0);
        chk("mrst_addr", {29'd0, bus.RAM_Write_Address}, 32'd0);
        chk("mrst_data", {21'd0, bus.RAM_Write_Data}, 32'd0);
        chk("mrst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        chk("mrst_pc", {31'd0, bus.PC_Enable}, 32'd0);
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_done", {31'd0, bus.done}, 32'd0);
        chk("mrst_error", {31'd0, bus.error}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        fill_random();
        run_seq(4, 6, 1, 0);

        // Randomized sequences, including illegal counts
        for (int n = 0; n < 25; n++) begin
            int lc;
            lc = int'($urandom_range(0, 12));
            fill_random();
            if (lc == 0 || lc > 8)
                illegal_seq(lc);
            else
                run_seq(lc, int'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
